// File: rtl/fifo_pkg.sv
// Shared defaults and FSM state type for the FIFO word packer.
package fifo_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_LANES      = 4;
    localparam int DEF_TIMEOUT    = 16;

    typedef enum logic {
        FILL = 1'b0,
        OUT  = 1'b1
    } pack_state_t;

endpackage

// File: rtl/fifo_pack_timer.sv
// Idle-cycle counter for partial-word flushing; expired is registered and
// holds while the count sits at TIMEOUT.
module fifo_pack_timer
    import fifo_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam logic [7:0] LIMIT = 8'(TIMEOUT);

    logic [7:0] r_count;
    logic       r_expired;
    logic [7:0] w_count_next;

    // Next count: restart on any read or when not timing, saturate at the limit.
    always_comb begin
        w_count_next = r_count;
        if (clear || !run) begin
            w_count_next = 8'd0;
        end else if (r_count != LIMIT) begin
            w_count_next = r_count + 8'd1;
        end else begin
            w_count_next = r_count;
        end
    end

    // Counter and expiry flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count   <= 8'd0;
            r_expired <= 1'b0;
        end else begin
            r_count   <= w_count_next;
            r_expired <= (w_count_next == LIMIT);
        end
    end

    assign expired = r_expired;

endmodule

// File: rtl/fifo_word_packer.sv
// Packs LANES FIFO entries into one word, lane 0 in the low bits.
// Define PACK_TIMEOUT_EN to flush partial words after TIMEOUT idle cycles.
module fifo_word_packer
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int LANES      = DEF_LANES,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                        rd_clk,
    input  logic                        rst_n,
    input  logic                        fifo_empty,
    output logic                        fifo_rd_en,
    input  logic [DATA_WIDTH-1:0]       fifo_dout,
    output logic [LANES*DATA_WIDTH-1:0] m_data,
    output logic [LANES-1:0]            m_keep,
    output logic                        m_valid,
    input  logic                        m_ready
);

    localparam int              CNT_W    = $clog2(LANES + 1);
    localparam logic [CNT_W:0]  LANES_W  = (CNT_W + 1)'(LANES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LANES - 1);

    pack_state_t                 r_state;
    logic [CNT_W-1:0]            r_lane_cnt;
    logic                        r_inflight;
    logic [LANES*DATA_WIDTH-1:0] r_data;
    logic [LANES-1:0]            r_keep;
    logic                        r_valid;

    logic [CNT_W:0]              w_occupancy;
    logic                        w_rd_en;
    logic                        w_last;
    logic                        w_flush;
    logic [LANES-1:0]            w_keep_partial;

    // Bytes already captured plus one still in flight must leave room for another read.
    assign w_occupancy = {1'b0, r_lane_cnt} + {{CNT_W{1'b0}}, r_inflight};
    assign w_rd_en     = rst_n && (r_state == FILL) && !fifo_empty && (w_occupancy < LANES_W);
    assign w_last      = r_inflight && (r_lane_cnt == CNT_LAST);

`ifdef PACK_TIMEOUT_EN
    logic w_timer_run;
    logic w_expired;

    assign w_timer_run = (r_state == FILL) && (r_lane_cnt != {CNT_W{1'b0}});

    fifo_pack_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (rd_clk),
        .rst_n   (rst_n),
        .clear   (w_rd_en),
        .run     (w_timer_run),
        .expired (w_expired)
    );

    // Never flush while a byte is still owed to the current word.
    assign w_flush = w_expired && w_timer_run && !r_inflight && !w_rd_en;
`else
    assign w_flush = 1'b0;
`endif

    // Lane-valid mask for a partial word: one bit per captured lane.
    always_comb begin
        w_keep_partial = {LANES{1'b0}};
        for (int k = 0; k < LANES; k++) begin
            w_keep_partial[k] = (k < int'(r_lane_cnt));
        end
    end

    // Packing FSM with registered output word, mask and valid.
    always_ff @(posedge rd_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= FILL;
            r_lane_cnt <= {CNT_W{1'b0}};
            r_inflight <= 1'b0;
            r_data     <= {(LANES*DATA_WIDTH){1'b0}};
            r_keep     <= {LANES{1'b0}};
            r_valid    <= 1'b0;
        end else begin
            r_inflight <= w_rd_en;
            case (r_state)
                FILL: begin
                    if (r_inflight) begin
                        // Lane 0 starts a fresh word, so unused lanes read back as zero.
                        if (r_lane_cnt == {CNT_W{1'b0}}) begin
                            r_data <= {{((LANES-1)*DATA_WIDTH){1'b0}}, fifo_dout};
                        end else begin
                            r_data[int'(r_lane_cnt)*DATA_WIDTH +: DATA_WIDTH] <= fifo_dout;
                        end
                        r_lane_cnt <= r_lane_cnt + CNT_ONE;
                        if (w_last) begin
                            r_state <= OUT;
                            r_valid <= 1'b1;
                            r_keep  <= {LANES{1'b1}};
                        end else begin
                            r_state <= FILL;
                        end
                    end else if (w_flush) begin
                        r_state <= OUT;
                        r_valid <= 1'b1;
                        r_keep  <= w_keep_partial;
                    end else begin
                        r_state <= FILL;
                    end
                end
                OUT: begin
                    if (m_ready) begin
                        r_state    <= FILL;
                        r_lane_cnt <= {CNT_W{1'b0}};
                        r_valid    <= 1'b0;
                        r_keep     <= {LANES{1'b0}};
                    end else begin
                        r_state <= OUT;
                    end
                end
                default: begin
                    r_state    <= FILL;
                    r_lane_cnt <= {CNT_W{1'b0}};
                    r_valid    <= 1'b0;
                    r_keep     <= {LANES{1'b0}};
                end
            endcase
        end
    end

    assign fifo_rd_en = w_rd_en;
    assign m_data     = r_data;
    assign m_keep     = r_keep;
    assign m_valid    = r_valid;

endmodule

// File: doc/fifo_word_packer.md
FIFO_WORD_PACKER -- requirements
Module: fifo_word_packer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, the FIFO entry width in bits.
REQ-002 The block SHALL have parameter LANES, default 4, the number of entries packed per output word; legal values are 2 to 8.
REQ-003 The block SHALL have parameter TIMEOUT, default 16, the number of idle cycles before a partial word is flushed; legal values are 2 to 255.
REQ-004 Port rd_clk SHALL be an input, 1 bit: the single clock, the FIFO read-side clock.
REQ-005 Port rst_n SHALL be an input, 1 bit: asynchronous, active-low reset.
REQ-006 Port fifo_empty SHALL be an input, 1 bit: the FIFO empty flag.
REQ-007 Port fifo_rd_en SHALL be an output, 1 bit: the FIFO read request.
REQ-008 Port fifo_dout SHALL be an input, DATA_WIDTH bits: FIFO read data, valid in the cycle after an accepted read.
REQ-009 Port m_data SHALL be an output, LANES*DATA_WIDTH bits: the packed word.
REQ-010 Port m_keep SHALL be an output, LANES bits: the lane-valid mask.
REQ-011 Port m_valid SHALL be an output, 1 bit: the output word is valid.
REQ-012 Port m_ready SHALL be an input, 1 bit: the downstream consumer accepts the word.

Function
REQ-013 The FSM SHALL have two states, FILL and OUT, and SHALL enter FILL on reset.
REQ-014 A FIFO read SHALL be accepted when fifo_rd_en=1 and fifo_empty=0; fifo_rd_en SHALL be asserted only under that condition.
REQ-015 In FILL, fifo_rd_en SHALL equal !fifo_empty && (lane_cnt + inflight < LANES), where inflight=1 if a read was accepted in the previous cycle.
REQ-016 The byte returned by an accepted read SHALL be captured one cycle later into lane lane_cnt, and lane_cnt SHALL then increment.
REQ-017 Lane 0, the first byte read, SHALL occupy m_data[DATA_WIDTH-1:0]; lane k SHALL occupy bits [(k+1)*DATA_WIDTH-1 : k*DATA_WIDTH].
REQ-018 When lane_cnt reaches LANES, the FSM SHALL move to OUT in the next cycle, with m_valid=1 and m_keep all-ones.
REQ-019 In OUT, fifo_rd_en SHALL be 0.
REQ-020 In OUT, m_data, m_keep and m_valid SHALL stay stable until m_ready=1.
REQ-021 On the cycle with m_valid=1 and m_ready=1, the FSM SHALL return to FILL and clear lane_cnt, m_valid and m_keep; m_data SHALL hold its last value.
REQ-022 An m_ready asserted while m_valid=0 SHALL have no effect.
REQ-023 Latency SHALL be: first accepted read to m_valid = LANES+1 cycles when the FIFO stays non-empty; sustained throughput is one word per LANES+2 cycles.
REQ-024 lane_cnt SHALL be $clog2(LANES+1) bits wide and SHALL never exceed LANES.
REQ-025 If fifo_empty rises while a read is in flight, the in-flight byte SHALL still be captured.

Reset
REQ-026 While rst_n=0, outputs SHALL be: m_valid=0, m_keep=0, m_data=0, fifo_rd_en=0 (combinationally gated); internally lane_cnt=0, the timer=0 and state=FILL.
REQ-027 A reset asserted mid-word SHALL discard the partial word and any in-flight byte without emitting them.
REQ-028 Reset assertion SHALL be asynchronous; release SHALL take effect on the first rd_clk edge after rst_n rises.

Configuration
REQ-029 Macro PACK_TIMEOUT_EN, when defined, SHALL enable timeout flushing: in FILL with lane_cnt>0 and no accepted read for TIMEOUT consecutive cycles, the FSM SHALL enter OUT with m_keep = (1<<lane_cnt)-1 and unused lanes of m_data set to zero.
REQ-030 Any accepted read SHALL reset the timeout counter.
REQ-031 Without PACK_TIMEOUT_EN, only full words SHALL be emitted, and partial bytes SHALL wait indefinitely.

Structure
REQ-032 Shared package fifo_pkg SHALL hold the DATA_WIDTH/LANES/TIMEOUT defaults and the state enum (FILL, OUT).
REQ-033 The timeout counter SHALL be the sub-module fifo_pack_timer (inputs: clear, run; output: expired); it is instantiated only under PACK_TIMEOUT_EN.

Verification
REQ-034 Push 0x11,0x22,0x33,0x44 with m_ready=1 -> one beat m_data=0x44332211, m_keep=4'b1111, exactly one m_valid cycle.
REQ-035 Push 8 bytes 0x01..0x08 with m_ready held 0 for 10 cycles -> 0x04030201 stays stable, fifo_rd_en=0 throughout, then 0x08070605 follows.
REQ-036 With PACK_TIMEOUT_EN, push 0xAA,0xBB then keep the FIFO empty -> after 16 idle cycles m_data=0x0000BBAA, m_keep=4'b0011.
REQ-037 Without PACK_TIMEOUT_EN, the same stimulus as REQ-036 -> no m_valid for 100 cycles; pushing 0xCC,0xDD then gives 0xDDCCBBAA.
REQ-038 rst_n pulsed low after 2 of 4 bytes captured -> all outputs are 0 immediately; the next 4 bytes 0x05..0x08 give 0x08070605.
REQ-039 fifo_empty toggles every cycle while 4 bytes arrive -> no read is issued while empty=1, and the word is correct with no duplicate or lost byte.
